mac_share_arbiter: RTL and testbench

Round-robin scheduler that shares one 18-bit multiply-accumulate datapath (out = a*b + c, truncated to DATA_WIDTH) among NUM_REQ independent requesters. It accepts at most one operand triple per cycle via per-requester valid/ready handshakes. It pushes the triple through a 2-stage pipeline and returns the result tagged with the requester index on a single response channel with backpressure. It sits between the requesting engines of a benchmark design and the MAC datapath they would otherwise each duplicate.

---
 rtl/mac_share_pkg.sv | 16 +
 rtl/mac_share_arbiter_rr.sv | 52 +++++
 rtl/mac_share_arbiter.sv | 96 +++++++++
 tb/tb_mac_share_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mac_share_pkg.sv
// mac_share_pkg: shared widths and the pipeline entry type
// for the shared multiply-accumulate arbiter.
package mac_share_pkg;

  localparam int DATA_WIDTH = 18;
  localparam int NUM_REQ    = 4;
  localparam int ID_WIDTH   = $clog2(NUM_REQ);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] c;
  } mac_entry_t;

endpackage

// File: rtl/mac_share_arbiter_rr.sv
// rr_arbiter: round-robin grant over req, searched from ptr with wrap.
// Ports: req/en in; gnt (one-hot), gnt_idx, gnt_any out; owns ptr.
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req,
  input  logic                en,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [ID_WIDTH-1:0] gnt_idx,
  output logic                gnt_any
);

  logic [ID_WIDTH-1:0] ptr;
  logic [ID_WIDTH-1:0] idx;

  function automatic logic [ID_WIDTH-1:0] wrap(
    logic [ID_WIDTH-1:0] p,
    int                  i
  );
    int j;
    j = int'(p) + i;
    if (j >= NUM_REQ) j = j - NUM_REQ;
    return ID_WIDTH'(j);
  endfunction

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = wrap(ptr, i);
      if (en && !gnt_any && req[idx]) begin
        gnt_any  = 1'b1;
        gnt_idx  = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= wrap(gnt_idx, 1);
    end
  end

endmodule

// File: rtl/mac_share_arbiter.sv
// mac_share_arbiter: shares one a*b+c datapath among NUM_REQ requesters.
// Ports: req_valid/req_ready/req_a/b/c in, resp_valid/ready/id/out, busy.
module mac_share_arbiter
  import mac_share_pkg::*;
#(
  parameter int DATA_WIDTH = mac_share_pkg::DATA_WIDTH,
  parameter int NUM_REQ    = mac_share_pkg::NUM_REQ,
  parameter int ID_WIDTH   = mac_share_pkg::ID_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_c,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ID_WIDTH-1:0]           resp_id,
  output logic [DATA_WIDTH-1:0]         resp_out,
  output logic                          busy
);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] c;
  } s1_t;

  localparam int PW = 2 * DATA_WIDTH;

  logic                adv;
  logic                gnt_en;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_WIDTH-1:0] gnt_idx;
  logic                gnt_any;
  logic                s1_valid;
  s1_t                 s1;
  logic [PW-1:0]       prod;
  logic [PW-1:0]       addend;

  assign adv = !resp_valid || resp_ready;
  // no grants while reset is held
  assign gnt_en = adv && rst_n;
  assign req_ready = gnt;
  assign busy = s1_valid || resp_valid;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .en      (gnt_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (adv) begin
      s1_valid <= gnt_any;
      if (gnt_any) begin
        s1.id <= gnt_idx;
        s1.a  <= req_a[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        s1.b  <= req_b[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        s1.c  <= req_c[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // full-width product, then wrap to DATA_WIDTH on load
  assign prod   = {{DATA_WIDTH{1'b0}}, s1.a}
                * {{DATA_WIDTH{1'b0}}, s1.b};
  assign addend = {{DATA_WIDTH{1'b0}}, s1.c};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_out   <= '0;
    end else if (adv) begin
      resp_valid <= s1_valid;
      if (s1_valid) begin
        resp_id  <= s1.id;
        resp_out <= DATA_WIDTH'(prod + addend);
      end
    end
  end

endmodule

// File: tb/tb_mac_share_arbiter.sv
// tb_mac_share_arbiter: table-driven cycle vectors plus
// hand-written reset-in-flight sequence.
module tb_mac_share_arbiter;

  localparam int W  = 18;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic [N*W-1:0]  req_c;
  logic            resp_valid;
  logic            resp_ready;
  logic [IW-1:0]   resp_id;
  logic [W-1:0]    resp_out;
  logic            busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mac_share_arbiter #(
    .DATA_WIDTH (W),
    .NUM_REQ    (N),
    .ID_WIDTH   (IW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_c      (req_c),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_out   (resp_out),
    .busy       (busy)
  );

  typedef struct {
    logic [3:0]  v;
    logic [17:0] a;
    logic [17:0] b;
    logic [17:0] c;
    logic        rdy;
    logic [3:0]  e_rr;
    logic        e_rv;
    logic [1:0]  e_id;
    logic [17:0] e_out;
    logic        e_busy;
  } vec_t;

  vec_t tv[25];

  function automatic vec_t mk(
    logic [3:0] v, logic [17:0] a, logic [17:0] b,
    logic [17:0] c, logic rdy, logic [3:0] e_rr,
    logic e_rv, logic [1:0] e_id, logic [17:0] e_out,
    logic e_busy
  );
    vec_t r;
    r.v = v; r.a = a; r.b = b; r.c = c; r.rdy = rdy;
    r.e_rr = e_rr; r.e_rv = e_rv; r.e_id = e_id;
    r.e_out = e_out; r.e_busy = e_busy;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // requester i presents a+i, b, c
  task automatic drive(logic [3:0] v, logic [17:0] a,
                       logic [17:0] b, logic [17:0] c, logic rdy);
    req_valid  = v;
    resp_ready = rdy;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a + 18'(i);
      req_b[i*W +: W] = b;
      req_c[i*W +: W] = c;
    end
  endtask

  task automatic check_all(string tag, logic [3:0] rr, logic rv,
                           logic [1:0] id, logic [17:0] o, logic bz,
                           logic chk_data);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(rr));
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'(rv));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
    if (chk_data) begin
      chk({tag, ".resp_id"}, 32'(resp_id), 32'(id));
      chk({tag, ".resp_out"}, 32'(resp_out), 32'(o));
    end
  endtask

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    tv[0]  = mk(4'b0001, 3, 5, 7, 1, 4'b0001, 0, 0, 0, 0);
    tv[1]  = mk(4'b0000, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 1);
    tv[2]  = mk(4'b0000, 0, 0, 0, 1, 4'b0000, 1, 0, 22, 1);
    tv[3]  = mk(4'b0000, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0);
    tv[4]  = mk(4'b0001, 18'h3FFFF, 18'h3FFFF, 1, 1,
                4'b0001, 0, 0, 0, 0);
    tv[5]  = mk(4'b1111, 1, 2, 3, 1, 4'b0010, 0, 0, 0, 1);
    tv[6]  = mk(4'b1111, 1, 2, 3, 1, 4'b0100, 1, 0, 2, 1);
    tv[7]  = mk(4'b1111, 1, 2, 3, 1, 4'b1000, 1, 1, 7, 1);
    tv[8]  = mk(4'b1111, 1, 2, 3, 1, 4'b0001, 1, 2, 9, 1);
    tv[9]  = mk(4'b1111, 1, 2, 3, 1, 4'b0010, 1, 3, 11, 1);
    for (int k = 10; k < 15; k++)
      tv[k] = mk(4'b1111, 1, 2, 3, 0, 4'b0000, 1, 0, 5, 1);
    tv[15] = mk(4'b0000, 0, 0, 0, 1, 4'b0000, 1, 0, 5, 1);
    tv[16] = mk(4'b0000, 0, 0, 0, 1, 4'b0000, 1, 1, 7, 1);
    tv[17] = mk(4'b0000, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0);
    tv[18] = mk(4'b1010, 10, 1, 0, 1, 4'b1000, 0, 0, 0, 0);
    tv[19] = mk(4'b1010, 10, 1, 0, 1, 4'b0010, 0, 0, 0, 1);
    tv[20] = mk(4'b0010, 10, 1, 0, 1, 4'b0010, 1, 3, 13, 1);
    tv[21] = mk(4'b0010, 10, 1, 0, 1, 4'b0010, 1, 1, 11, 1);
    tv[22] = mk(4'b0000, 0, 0, 0, 1, 4'b0000, 1, 1, 11, 1);
    tv[23] = mk(4'b0000, 0, 0, 0, 1, 4'b0000, 1, 1, 11, 1);
    tv[24] = mk(4'b0000, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0);

    rst_n = 1'b0;
    drive(4'b1111, 9, 9, 9, 1);
    @(negedge clk);
    #1;
    check_all("reset", 4'b0000, 0, 0, 0, 0, 1);

    @(negedge clk);
    drive(4'b0000, 0, 0, 0, 1);
    rst_n = 1'b1;

    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      drive(tv[k].v, tv[k].a, tv[k].b, tv[k].c, tv[k].rdy);
      #1;
      check_all($sformatf("row%0d", k), tv[k].e_rr, tv[k].e_rv,
                tv[k].e_id, tv[k].e_out, tv[k].e_busy, tv[k].e_rv);
    end

    // fill pipeline, then reset with two entries in flight
    @(negedge clk);
    drive(4'b1111, 20, 1, 0, 1);
    #1;
    check_all("fill0", 4'b0100, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check_all("fill1", 4'b1000, 0, 0, 0, 1, 0);
    @(negedge clk);
    #1;
    check_all("fill2", 4'b0001, 1, 2, 22, 1, 1);
    rst_n = 1'b0;
    #1;
    check_all("rst_mid", 4'b0000, 0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    check_all("rst_hold", 4'b0000, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
    drive(4'b0110, 20, 1, 0, 1);
    #1;
    check_all("post_rst_gnt", 4'b0010, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(4'b0000, 0, 0, 0, 1);
    #1;
    check_all("no_stale", 4'b0000, 0, 0, 0, 1, 0);
    @(negedge clk);
    #1;
    check_all("post_rst_resp", 4'b0000, 1, 1, 21, 1, 1);
    @(negedge clk);
    #1;
    check_all("drained", 4'b0000, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
